// File: rtl/lbm_gather_seq.sv
// Sequential gather of one 9-lane distribution vector per mux source, with
// per-lane signed accumulation across the sweep and a single-beat output hold.
module lbm_gather_seq #(
  parameter int DATA_WIDTH = 288,
  parameter int NUM_SRC    = 11
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  output logic [3:0]            select,
  input  logic [DATA_WIDTH-1:0] mux_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [9*36-1:0]       lane_sum,
  output logic [1:0]            state_dbg
);

  localparam int LANES = 9;
  localparam int LW    = 32;
  localparam int AW    = 36;
  localparam logic [3:0] LAST_IDX = 4'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        idx;
  logic [9*36-1:0]   sum_next;

  assign select    = idx;
  assign state_dbg = state;

  // Each lane is sign-extended to the accumulator width; 36 bits cover 16 sources.
  always_comb begin
    sum_next = lane_sum;
    for (int k = 0; k < LANES; k++) begin
      sum_next[AW*k +: AW] = lane_sum[AW*k +: AW]
                           + {{(AW-LW){mux_data[LW*k + LW-1]}}, mux_data[LW*k +: LW]};
    end
  end

  // Handshake: a beat is presented with out_valid and transfers on the rising
  // edge where out_valid & out_ready are both 1; until then out_data/out_idx
  // and out_valid stay frozen and out_valid never drops without a transfer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      out_data  <= '0;
      out_idx   <= 4'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lane_sum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            idx      <= 4'd0;
            lane_sum <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          out_data  <= mux_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
          lane_sum  <= sum_next;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 4'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_idx_range: assert property (@(posedge Clk) disable iff (Reset)
    out_valid |-> (int'(out_idx) < NUM_SRC));

  a_hold_stable: assert property (@(posedge Clk) disable iff (Reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_idx)));

endmodule
